// File: rtl/div_arb_pkg.sv
// Shared types and helpers for the divider arbiter: FSM state encoding and
// pointer sizing.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } div_arb_state_t;

  localparam int K_NREQ_DEF = 4;
  localparam int PTR_W_DEF  = $clog2(K_NREQ_DEF);

  // Index width for a given requester count, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// Combinational round-robin select: the first set request at or after ptr,
// wrapping circularly, returned as one-hot grant and binary index.
module rr_picker
  import div_arb_pkg::*;
#(
  parameter int N  = K_NREQ_DEF,
  parameter int PW = PTR_W_DEF
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (PW'(gi) >= ptr);
    end
  endgenerate

  assign masked = req & hi_mask;
  // Nothing at or above ptr means the search wraps to the bottom.
  assign sel    = (|masked) ? masked : req;
  assign any    = |req;

  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i] && !found) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = PW'(i);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among K_NREQ requesters: buffers requests,
// grants round-robin, launches, watches for a result and returns it per channel.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int K_NREQ    = K_NREQ_DEF,
  parameter int K_WIDTH   = 8,
  parameter int K_TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [K_NREQ-1:0]         i_req,
  input  logic [K_NREQ*K_WIDTH-1:0] i_x,
  input  logic [K_NREQ*K_WIDTH-1:0] i_y,
  output logic [K_NREQ-1:0]         o_pending,
  output logic [K_NREQ-1:0]         o_done,
  output logic [K_NREQ*K_WIDTH-1:0] o_q,
  output logic [K_NREQ*K_WIDTH-1:0] o_r,
  output logic [K_NREQ-1:0]         o_err,
  output logic                      o_timeout,
  output logic                      o_div_start,
  output logic [K_WIDTH-1:0]        o_div_x,
  output logic [K_WIDTH-1:0]        o_div_y,
  input  logic                      i_div_busy,
  input  logic                      i_div_valid,
  input  logic                      i_div_dbz,
  input  logic                      i_div_ovf,
  input  logic [K_WIDTH-1:0]        i_div_q,
  input  logic [K_WIDTH-1:0]        i_div_r
);

  localparam int PW  = ptr_width(K_NREQ);
  localparam int WDW = $clog2(K_TIMEOUT);

  div_arb_state_t     state_reg;
  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      g_reg;
  logic [WDW-1:0]     wd_reg;
  logic               start_reg;
  logic               timeout_reg;
  logic [K_WIDTH-1:0] div_x_reg;
  logic [K_WIDTH-1:0] div_y_reg;

  logic [K_NREQ-1:0]  pend_reg;
  logic [K_NREQ-1:0]  done_reg;
  logic [K_NREQ-1:0]  err_reg;
  logic [K_WIDTH-1:0] buf_x_reg [K_NREQ];
  logic [K_WIDTH-1:0] buf_y_reg [K_NREQ];
  logic [K_WIDTH-1:0] q_reg     [K_NREQ];
  logic [K_WIDTH-1:0] r_reg     [K_NREQ];

  logic [K_NREQ-1:0]  pick_grant;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               launch_fire;
  logic               fin_valid;
  logic               fin_timeout;
  logic [PW-1:0]      ptr_next;

  rr_picker #(
    .N  (K_NREQ),
    .PW (PW)
  ) u_picker (
    .req   (pend_reg),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign launch_fire = (state_reg == IDLE) && pick_any && !i_div_busy;
  assign fin_valid   = (state_reg == WAIT) && i_div_valid;
  assign fin_timeout = (state_reg == WAIT) && !i_div_valid &&
                       (wd_reg == WDW'(K_TIMEOUT - 1));
  assign ptr_next    = (pick_idx == PW'(K_NREQ - 1)) ? '0 : pick_idx + PW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      g_reg       <= '0;
      wd_reg      <= '0;
      start_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      div_x_reg   <= '0;
      div_y_reg   <= '0;
    end else begin
      start_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (launch_fire) begin
            g_reg     <= pick_idx;
            ptr_reg   <= ptr_next;
            div_x_reg <= buf_x_reg[pick_idx];
            div_y_reg <= buf_y_reg[pick_idx];
            start_reg <= 1'b1;
            state_reg <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_reg    <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          wd_reg <= wd_reg + WDW'(1);
          if (fin_valid) begin
            state_reg <= IDLE;
          end else if (fin_timeout) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < K_NREQ; gi++) begin : g_chan
      logic is_g;
      assign is_g = (g_reg == PW'(gi));

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          pend_reg[gi]  <= 1'b0;
          buf_x_reg[gi] <= '0;
          buf_y_reg[gi] <= '0;
          q_reg[gi]     <= '0;
          r_reg[gi]     <= '0;
          err_reg[gi]   <= 1'b0;
          done_reg[gi]  <= 1'b0;
        end else begin
          done_reg[gi] <= 1'b0;
          // A fresh request outranks the grant that would clear the bit.
          if (i_req[gi]) begin
            pend_reg[gi]  <= 1'b1;
            buf_x_reg[gi] <= i_x[gi*K_WIDTH +: K_WIDTH];
            buf_y_reg[gi] <= i_y[gi*K_WIDTH +: K_WIDTH];
          end else if (launch_fire && pick_grant[gi]) begin
            pend_reg[gi] <= 1'b0;
          end
          if (fin_valid && is_g) begin
            q_reg[gi]    <= i_div_q;
            r_reg[gi]    <= i_div_r;
            err_reg[gi]  <= i_div_dbz | i_div_ovf;
            done_reg[gi] <= 1'b1;
          end else if (fin_timeout && is_g) begin
            err_reg[gi]  <= 1'b1;
            done_reg[gi] <= 1'b1;
          end
        end
      end

      assign o_q[gi*K_WIDTH +: K_WIDTH] = q_reg[gi];
      assign o_r[gi*K_WIDTH +: K_WIDTH] = r_reg[gi];
    end
  endgenerate

  assign o_pending   = pend_reg;
  assign o_done      = done_reg;
  assign o_err       = err_reg;
  assign o_timeout   = timeout_reg;
  assign o_div_start = start_reg;
  assign o_div_x     = div_x_reg;
  assign o_div_y     = div_y_reg;

endmodule
